// File: rtl/xor_gate_tester.sv
// Truth-table tester for a quad 2-input XOR gate: sweeps all 256 {A,B} vectors,
// checks the synchronised Y against A^B and records the error count and the first failing vector.
module xor_gate_tester #(
  parameter int SETTLE_CYC   = 4,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic [3:0] A_OUT,
  output logic [3:0] B_OUT,
  input  logic [3:0] Y_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic       FAIL_VALID,
  output logic [7:0] FIRST_FAIL
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_vec;
  logic [CW-1:0]   r_wait;
  logic [3:0]      r_y_m, r_y_s;
  logic            r_busy, r_done, r_fv;
  logic [8:0]      r_err;
  logic [7:0]      r_ff;

  logic w_start, w_mis, w_last_wait, w_end;

  assign w_start     = START && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mis       = (r_y_s != (r_vec[7:4] ^ r_vec[3:0]));
  assign w_last_wait = (r_wait == CW'(SETTLE_CYC - 1));
  // Run ends on the last vector, or on the first mismatch when stopping early.
  assign w_end       = (r_vec == 8'hFF) || (STOP_ON_FAIL && w_mis);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_start) w_next = S_SETTLE;
      S_SETTLE:       if (w_last_wait) w_next = S_CHECK;
      S_CHECK:        w_next = w_end ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vec  <= '0;
      r_wait <= '0;
      r_y_m  <= '0;
      r_y_s  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fv   <= 1'b0;
      r_err  <= '0;
      r_ff   <= '0;
    end else begin
      r_y_m <= Y_IN;
      r_y_s <= r_y_m;
      if (w_start) begin
        r_vec  <= '0;
        r_wait <= '0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_fv   <= 1'b0;
        r_err  <= '0;
        r_ff   <= '0;
      end else begin
        unique case (r_state)
          S_SETTLE: if (!w_last_wait) r_wait <= r_wait + 1'b1;
          S_CHECK: begin
            if (w_mis) begin
              r_err <= r_err + 9'd1;
              if (!r_fv) begin
                r_ff <= r_vec;
                r_fv <= 1'b1;
              end
            end
            if (w_end) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_vec  <= r_vec + 8'd1;
              r_wait <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign A_OUT      = r_vec[7:4];
  assign B_OUT      = r_vec[3:0];
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign PASS       = r_done && (r_err == 9'd0);
  assign ERR_CNT    = r_err;
  assign FAIL_VALID = r_fv;
  assign FIRST_FAIL = r_ff;

endmodule

// File: tb/tb_xor_gate_tester.sv
// Bench for xor_gate_tester: two instances (run-all and stop-on-fail) share the
// stimulus; each drives its own modelled gate with a 1-cycle output delay.
module tb_xor_gate_tester;

  logic       CLK = 1'b0;
  logic       RST, START;
  logic [3:0] A_OUT, B_OUT, Y_IN, A_S, B_S, Y_S;
  logic       BUSY, DONE, PASS, FV, BUSY_S, DONE_S, PASS_S, FV_S;
  logic [8:0] ERR_CNT, ERR_S;
  logic [7:0] FIRST_FAIL, FF_S;

  int n_cmp = 0;
  int n_mis = 0;
  int mode  = 0;
  logic [3:0] mask [256];

  always #5 CLK = ~CLK;

  xor_gate_tester #(.SETTLE_CYC(4), .STOP_ON_FAIL(1'b0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A_OUT(A_OUT), .B_OUT(B_OUT), .Y_IN(Y_IN),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_VALID(FV),
    .FIRST_FAIL(FIRST_FAIL));

  xor_gate_tester #(.SETTLE_CYC(4), .STOP_ON_FAIL(1'b1)) dut_s (
    .CLK(CLK), .RST(RST), .START(START), .A_OUT(A_S), .B_OUT(B_S), .Y_IN(Y_S),
    .BUSY(BUSY_S), .DONE(DONE_S), .PASS(PASS_S), .ERR_CNT(ERR_S), .FAIL_VALID(FV_S),
    .FIRST_FAIL(FF_S));

  // Device under test model: 0 good XOR, 1 Y[2] stuck at 0, 2 XNOR, 3 random fault mask
  function automatic logic [3:0] gate(input int md, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] x;
    x = a ^ b;
    case (md)
      1:       return x & 4'b1011;
      2:       return ~x;
      3:       return x ^ mask[{a, b}];
      default: return x;
    endcase
  endfunction

  always @(posedge CLK) begin
    Y_IN <= gate(mode, A_OUT, B_OUT);
    Y_S  <= gate(mode, A_S, B_S);
  end

  typedef struct {
    int mode;
    int err;
    int ff;
    int fv;
    int pass;
    int s_err;
    int s_vec;
    int s_busy;
    int mid;
  } run_t;

  run_t runs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_run(input run_t t);
    int nb, nbs;
    bit fin;
    mode = t.mode;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    chk("start_busy", 32'(BUSY), 32'd1);
    chk("start_clear", {DONE, PASS, FV, ERR_CNT, FIRST_FAIL, A_OUT, B_OUT}, 32'd0);
    nb = 0; nbs = 0; fin = 1'b0;
    for (int n = 0; n < 2000 && !fin; n++) begin
      if (BUSY)   nb++;
      if (BUSY_S) nbs++;
      if (DONE && DONE_S) fin = 1'b1;
      else begin
        @(negedge CLK);
        START = (t.mid != 0) && (n + 1 == t.mid);
      end
    end
    START = 1'b0;
    chk("run_finished", 32'(fin), 32'd1);
    chk("busy_cycles", 32'(nb), 32'd1280);
    chk("busy_low", 32'(BUSY), 32'd0);
    chk("pass", 32'(PASS), 32'(t.pass));
    chk("err_cnt", 32'(ERR_CNT), 32'(t.err));
    chk("fail_valid", 32'(FV), 32'(t.fv));
    chk("first_fail", 32'(FIRST_FAIL), 32'(t.ff));
    chk("last_vec", 32'({A_OUT, B_OUT}), 32'hFF);
    chk("stop_busy_cycles", 32'(nbs), 32'(t.s_busy));
    chk("stop_err_cnt", 32'(ERR_S), 32'(t.s_err));
    chk("stop_held_vec", 32'({A_S, B_S}), 32'(t.s_vec));
  endtask

  // Reference expectations for a random fault mask, from the sweep's rules.
  function automatic run_t model_rand();
    run_t r;
    int first;
    first = -1;
    r.err = 0;
    for (int v = 0; v < 256; v++)
      if (mask[v] != 4'd0) begin
        r.err++;
        if (first < 0) first = v;
      end
    r.mode   = 3;
    r.fv     = (first >= 0);
    r.ff     = (first >= 0) ? first : 0;
    r.pass   = (first < 0);
    r.s_err  = (first >= 0) ? 1 : 0;
    r.s_vec  = (first >= 0) ? first : 255;
    r.s_busy = (first >= 0) ? (first + 1) * 5 : 1280;
    r.mid    = 0;
    return r;
  endfunction

  initial begin
    bit hit;
    RST = 1'b1; START = 1'b0;
    for (int v = 0; v < 256; v++) mask[v] = 4'd0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {BUSY, DONE, PASS, FV, ERR_CNT, FIRST_FAIL, A_OUT, B_OUT}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    //          mode err  ff fv pass s_err s_vec s_busy mid
    runs.push_back('{0,   0,  0, 0, 1,   0,  255,  1280, 100});
    runs.push_back('{1, 128,  4, 1, 0,   1,    4,    25,   0});
    runs.push_back('{2, 256,  0, 1, 0,   1,    0,     5,   0});
    runs.push_back('{0,   0,  0, 0, 1,   0,  255,  1280,   0});
    foreach (runs[i]) do_run(runs[i]);

    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 256; v++)
        mask[v] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if (r == 2) mask[255] = 4'h8;
      do_run(model_rand());
    end

    // Mid-run reset at vector 0x80: async clear, no DONE afterwards
    mode = 0;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      if ({A_OUT, B_OUT} == 8'h80) hit = 1'b1;
      else @(negedge CLK);
    end
    chk("reached_vec_80", 32'(hit), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("mid_reset_outputs", {BUSY, DONE, PASS, FV, ERR_CNT, FIRST_FAIL, A_OUT, B_OUT}, 32'd0);
    chk("mid_reset_stop_dut", {BUSY_S, DONE_S, FV_S, ERR_S, A_S, B_S}, 32'd0);
    @(negedge CLK); RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("no_done_after_reset", {BUSY, DONE, A_OUT, B_OUT}, 32'd0);
    do_run(runs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
